// File: rtl/cpu32_pkg.sv
// cpu32_pkg: shared definitions for the write-back stage.
//   - write-back op bit positions (WB_OP_*)
//   - write-back sequencer state encoding (wb_state_t)
//   - status flag bit positions inside st[3:0] (ST_*)
//   - pack_flags(): assembles {n,z,c,v} into the status nibble layout
package cpu32_pkg;

  localparam int unsigned WB_OP_W1 = 32'd0;
  localparam int unsigned WB_OP_W2 = 32'd1;
  localparam int unsigned WB_OP_ST = 32'd2;

  localparam int unsigned ST_N = 32'd3;
  localparam int unsigned ST_Z = 32'd2;
  localparam int unsigned ST_C = 32'd1;
  localparam int unsigned ST_V = 32'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } wb_state_t;

  // Places each flag at its architectural bit position.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f       = 4'd0;
    f[ST_N] = n;
    f[ST_Z] = z;
    f[ST_C] = c;
    f[ST_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/wb_status_reg.sv
// wb_status_reg: architectural status register (N,Z,C,V), zero-extended to 32 bits.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-low reset
//   we        in   load flags_in at the next rising edge
//   flags_in  in   4-bit flag nibble, already in ST_* layout
//   st        out  32-bit status word, st[31:4] always 0
module wb_status_reg
  import cpu32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  flags_in,
  output logic [31:0] st
);

  logic [3:0] flags_r;

  // Flag storage; reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_r <= 4'd0;
    end else if (we) begin
      flags_r <= flags_in;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign st = {28'd0, flags_r};

endmodule

// File: rtl/writeback_sequencer.sv
// writeback_sequencer: retires execute result bundles into a single-write-port
// register file, serialising dual writes over two cycles, and owns the status
// register.
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   in_valid/in_ready  bundle handshake (accept = both high at a rising edge)
//   r1, r2             results; r_a1, r_a2 their destinations
//   r_op               [0] write r1, [1] write r2, [2] write flags, [3] ignored
//   cres               condition passed; 0 squashes the bundle
//   n, z, c, v, stwr   flags and flag-write enable from execute
//   rf_we/rf_wa/rf_wd  registered register-file write port
//   st                 status word {28'b0, n, z, c, v}
module writeback_sequencer
  import cpu32_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  input  logic [AW-1:0] r_a1,
  input  logic [AW-1:0] r_a2,
  input  logic [3:0]    r_op,
  input  logic          cres,
  input  logic          n,
  input  logic          z,
  input  logic          c,
  input  logic          v,
  input  logic          stwr,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [31:0]   st
);

  wb_state_t     state_r, state_nxt_s;
  logic          pend2_r, pend2_nxt_s;
  logic [DW-1:0] r2_hold_r, r2_hold_nxt_s;
  logic [AW-1:0] a2_hold_r, a2_hold_nxt_s;
  logic          rf_we_r, rf_we_nxt_s;
  logic [AW-1:0] rf_wa_r, rf_wa_nxt_s;
  logic [DW-1:0] rf_wd_r, rf_wd_nxt_s;

  logic in_ready_s;
  logic accept_s;
  logic w1_s;
  logic w2_s;
  logic take_new_s;
  logic st_we_s;
  logic unused_op_s;

  // r_op[3] is reserved; it is deliberately not decoded.
  assign unused_op_s = r_op[3];

  // Upstream may only be stalled while the held r2 write is still to go out.
  assign in_ready_s = (state_r == IDLE) | (state_r == WR_B) |
                      ((state_r == WR_A) & !pend2_r);
  assign accept_s   = in_valid & in_ready_s;

  // Register 0 is hardwired, so writes to it are dropped without a cycle.
  assign w1_s = cres & r_op[WB_OP_W1] & (r_a1 != {AW{1'b0}});
  assign w2_s = cres & r_op[WB_OP_W2] & (r_a2 != {AW{1'b0}});

  assign st_we_s = accept_s & cres & r_op[WB_OP_ST] & stwr;

  // Next-state, pending-write and write-port decode.
  always_comb begin
    state_nxt_s   = state_r;
    pend2_nxt_s   = pend2_r;
    r2_hold_nxt_s = r2_hold_r;
    a2_hold_nxt_s = a2_hold_r;
    rf_we_nxt_s   = 1'b0;
    rf_wa_nxt_s   = rf_wa_r;
    rf_wd_nxt_s   = rf_wd_r;
    take_new_s    = 1'b0;

    case (state_r)
      IDLE: begin
        take_new_s = 1'b1;
      end
      WR_A: begin
        if (pend2_r) begin
          state_nxt_s = WR_B;
          pend2_nxt_s = 1'b0;
          rf_we_nxt_s = 1'b1;
          rf_wa_nxt_s = a2_hold_r;
          rf_wd_nxt_s = r2_hold_r;
        end else begin
          take_new_s = 1'b1;
        end
      end
      WR_B: begin
        take_new_s = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
        pend2_nxt_s = 1'b0;
      end
    endcase

    // Any state able to take a bundle decodes it identically.
    if (take_new_s) begin
      state_nxt_s = IDLE;
      pend2_nxt_s = 1'b0;
      if (accept_s && w1_s) begin
        state_nxt_s = WR_A;
        rf_we_nxt_s = 1'b1;
        rf_wa_nxt_s = r_a1;
        rf_wd_nxt_s = r1;
        if (w2_s) begin
          pend2_nxt_s   = 1'b1;
          r2_hold_nxt_s = r2;
          a2_hold_nxt_s = r_a2;
        end else begin
          pend2_nxt_s = 1'b0;
        end
      end else if (accept_s && w2_s) begin
        state_nxt_s = WR_B;
        rf_we_nxt_s = 1'b1;
        rf_wa_nxt_s = r_a2;
        rf_wd_nxt_s = r2;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      take_new_s = 1'b0;
    end
  end

  // State, pending write and registered write port; reset drops any pending r2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      pend2_r   <= 1'b0;
      r2_hold_r <= {DW{1'b0}};
      a2_hold_r <= {AW{1'b0}};
      rf_we_r   <= 1'b0;
      rf_wa_r   <= {AW{1'b0}};
      rf_wd_r   <= {DW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pend2_r   <= pend2_nxt_s;
      r2_hold_r <= r2_hold_nxt_s;
      a2_hold_r <= a2_hold_nxt_s;
      rf_we_r   <= rf_we_nxt_s;
      rf_wa_r   <= rf_wa_nxt_s;
      rf_wd_r   <= rf_wd_nxt_s;
    end
  end

  wb_status_reg u_status (
    .clk      (clk),
    .rst      (rst),
    .we       (st_we_s),
    .flags_in (pack_flags(n, z, c, v)),
    .st       (st)
  );

  assign in_ready = in_ready_s;
  assign rf_we    = rf_we_r;
  assign rf_wa    = rf_wa_r;
  assign rf_wd    = rf_wd_r;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed testbench for writeback_sequencer with a timed strobe scoreboard.
module tb_writeback_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r1, r2;
  logic [4:0]  r_a1, r_a2;
  logic [3:0]  r_op;
  logic        cres, n, z, c, v, stwr;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] st;

  typedef struct {
    int          cyc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          ncmp;
  int          nerr;
  logic [31:0] rf_model [0:31];

  writeback_sequencer #(.AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .r_a1(r_a1), .r_a2(r_a2), .r_op(r_op), .cres(cres),
    .n(n), .z(z), .c(c), .v(v), .stwr(stwr),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .st(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expect a strobe (wa, wd) visible dt cycles from now.
  task automatic push(input int dt, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e.cyc = cyc + dt;
    e.wa  = wa;
    e.wd  = wd;
    q.push_back(e);
  endtask

  // One clock; sample at the falling edge and score the write port.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("strobe_we", {31'd0, rf_we}, 32'd1);
      chk("strobe_wa", {27'd0, rf_wa}, {27'd0, e.wa});
      chk("strobe_wd", rf_wd, e.wd);
    end else begin
      chk("no_strobe_we", {31'd0, rf_we}, 32'd0);
    end
    if (rf_we === 1'b1) begin
      rf_model[rf_wa] = rf_wd;
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2, input logic cr);
    in_valid = 1'b1;
    r_op     = op;
    r_a1     = a1;
    r1       = d1;
    r_a2     = a2;
    r2       = d2;
    cres     = cr;
  endtask

  initial begin
    ncmp = 0; nerr = 0; cyc = 0;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    rst = 1'b0; in_valid = 1'b0;
    r1 = 32'd0; r2 = 32'd0; r_a1 = 5'd0; r_a2 = 5'd0; r_op = 4'd0;
    cres = 1'b0; n = 1'b0; z = 1'b0; c = 1'b0; v = 1'b0; stwr = 1'b0;

    // Reset held for two edges.
    tick();
    tick();
    rst = 1'b1;
    chk("rst_st", st, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wa", {27'd0, rf_wa}, 32'd0);
    chk("rst_wd", rf_wd, 32'd0);

    // Dual write: (3,0x11) then (4,0x22), stalled during first strobe.
    drive(4'b0011, 5'd3, 32'h11, 5'd4, 32'h22, 1'b1);
    push(1, 5'd3, 32'h11);
    push(2, 5'd4, 32'h22);
    tick();
    in_valid = 1'b0;
    chk("dual_ready_wr_a", {31'd0, in_ready}, 32'd0);
    tick();
    chk("dual_ready_wr_b", {31'd0, in_ready}, 32'd1);
    tick();

    // Single-write bundles every cycle.
    for (int i = 1; i <= 3; i++) begin
      drive(4'b0001, i[4:0], 32'h100 + i, 5'd9, 32'hdead, 1'b1);
      chk("single_ready", {31'd0, in_ready}, 32'd1);
      push(1, i[4:0], 32'h100 + i);
      tick();
    end
    chk("single_ready_end", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();

    // Squashed bundle: no strobe, status unchanged.
    n = 1'b1; z = 1'b1; c = 1'b1; v = 1'b1; stwr = 1'b1;
    drive(4'b0111, 5'd6, 32'h66, 5'd7, 32'h67, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("squash_st", st, 32'd0);
    tick();

    // Flag write {n,z,c,v}=1010, no register writes.
    n = 1'b1; z = 1'b0; c = 1'b1; v = 1'b0;
    drive(4'b0111, 5'd0, 32'h1, 5'd0, 32'h2, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("flag_st", st, 32'h0000000A);
    tick();

    // stwr low: status holds.
    n = 1'b0; z = 1'b1; c = 1'b0; v = 1'b1; stwr = 1'b0;
    drive(4'b0100, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("stwr_low_st", st, 32'h0000000A);

    // Reserved op bit ignored: flags written to 0101.
    stwr = 1'b1;
    drive(4'b1100, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("op3_st", st, 32'h00000005);
    stwr = 1'b0;
    tick();

    // r_a1 = 0: only the write to register 5 happens, no stall.
    drive(4'b0011, 5'd0, 32'h50, 5'd5, 32'h55, 1'b1);
    push(1, 5'd5, 32'h55);
    tick();
    in_valid = 1'b0;
    chk("a1_zero_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Same destination: r1 then r2, file keeps r2.
    drive(4'b0011, 5'd7, 32'h77, 5'd7, 32'h78, 1'b1);
    push(1, 5'd7, 32'h77);
    push(2, 5'd7, 32'h78);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("same_dest_rf7", rf_model[7], 32'h78);
    chk("rf5", rf_model[5], 32'h55);

    // Reset during the first strobe of a dual write drops the second.
    drive(4'b0011, 5'd9, 32'h99, 5'd10, 32'haa, 1'b1);
    push(1, 5'd9, 32'h99);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_wa", {27'd0, rf_wa}, 32'd0);
    chk("midrst_wd", rf_wd, 32'd0);
    chk("midrst_st", st, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();

    // Reset has priority over a simultaneous accept.
    n = 1'b1; z = 1'b1; c = 1'b1; v = 1'b1; stwr = 1'b1;
    drive(4'b0101, 5'd3, 32'h33, 5'd0, 32'h0, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    stwr = 1'b0;
    chk("rstacc_st", st, 32'd0);
    tick();
    chk("rstacc_st2", st, 32'd0);

    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/writeback_sequencer.md
# writeback_sequencer

Final pipeline stage behind the execute stage. Takes each execute result bundle (two 32-bit results, two destination register addresses, write-back op, condition result, ALU flags) and retires it. The register file has one write port, so the two result writes are serialised over consecutive cycles. The block also owns the architectural status register and back-pressures upstream while a second write is pending.

## Interface
Parameters:
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset. Synchronous and active-low: sampled low at a rising `clk` resets the block.
- `in_valid`  in  1  result bundle present.
- `in_ready`  out  1  bundle accepted at this edge if `in_valid` is also high.
- `r1`, `r2`  in  DW  results 1 and 2.
- `r_a1`, `r_a2`  in  AW  destinations of `r1` and `r2`.
- `r_op`  in  4  write-back op:
  - bit0 writes `r1` to `r_a1`.
  - bit1 writes `r2` to `r_a2`.
  - bit2 writes flags.
  - bit3 is reserved and ignored.
- `cres`  in  1  condition passed. 0 squashes the whole bundle.
- `n`, `z`, `c`, `v`  in  1 each  flags from execute.
- `stwr`  in  1  flag-write enable from execute.
- `rf_we`  out  1  register file write strobe (registered).
- `rf_wa`  out  AW  register file write address (registered).
- `rf_wd`  out  DW  register file write data (registered).
- `st`  out  32  status register: `st[3:0]` = {n,z,c,v}; `st[31:4]` is always 0.

## Operation
- Accept occurs when `in_valid` and `in_ready` are both high at a rising edge. Only accepted bundles have any effect.
- Effective write enables at accept:
  - `w1 = cres & r_op[0] & (r_a1 != 0)`
  - `w2 = cres & r_op[1] & (r_a2 != 0)`
  - Register 0 is hardwired: a write to it is dropped and consumes no cycle.
- Status update: on accept, if `cres & r_op[2] & stwr`, then `st[3:0]` ← {n,z,c,v}. The new value is visible the cycle after accept.
- FSM states are IDLE, WR_A and WR_B.
  - IDLE, accept with `w1` → WR_A. With `w2` as well, latch `r2`/`r_a2` and set `pend2`.
  - IDLE, accept with only `w2` → WR_B.
  - IDLE, no accept, or accept with neither write → stays IDLE.
  - WR_A: `rf_we`=1, `rf_wa`/`rf_wd` = result 1. If `pend2`, go to WR_B with `in_ready`=0. Otherwise behave as IDLE for a new accept (back-to-back).
  - WR_B: `rf_we`=1, `rf_wa`/`rf_wd` = result 2. Clears `pend2`, then behaves as IDLE for a new accept.
- `in_ready = (state==IDLE) | (state==WR_B) | (state==WR_A & !pend2)`. It is combinational from state only and never depends on `in_valid`.
- Same destination for both writes: both strobes are issued, r1 first then r2, so r2 wins in the file.
- `rf_wa` and `rf_wd` hold their last value while `rf_we`=0.

## Timing
- Reset (rst=0 at an edge) sets:
  - state to IDLE, `pend2` to 0;
  - `rf_we`, `rf_wa`, `rf_wd` to 0;
  - `st` to 0.
  - `in_ready` is therefore 1 in the cycle after reset.
- Reset mid-sequence, in WR_A with `pend2` set, drops the pending r2 write. No strobe follows reset.
- Reset has priority over a simultaneous accept. That bundle is lost and `st` is not updated.
- Latency: the first strobe is asserted in the cycle after the accept edge. The second strobe follows in the next cycle.
- Throughput:
  - single-write bundles: 1 per cycle;
  - dual-write bundles: 1 per 2 cycles;
  - no-write bundles: 1 per cycle.
- A squashed bundle (`cres`=0) is still accepted and still consumes its handshake, but produces no strobe and no status change.

## Structure
- Shared package `cpu32_pkg` holds:
  - `WB_OP_W1`=0, `WB_OP_W2`=1, `WB_OP_ST`=2;
  - state enum `wb_state_t` {IDLE, WR_A, WR_B};
  - `ST_N`=3, `ST_Z`=2, `ST_C`=1, `ST_V`=0.
- One sub-module is natural: `wb_status_reg`. It is the 4-flag register with sync active-low reset and write enable, zero-extended to 32 bits.

## Test plan
- Reset held low for 2 edges, then released → `rf_we`=0, `st`=0, `in_ready`=1.
- Accept `r_op`=0011, `r_a1`=3, `r1`=0x11, `r_a2`=4, `r2`=0x22, `cres`=1:
  - strobes (3,0x11) then (4,0x22) on consecutive cycles;
  - `in_ready`=0 during the first strobe cycle.
- `r_op`=0001 bundles every cycle, destinations 1, 2, 3:
  - 3 consecutive strobes;
  - `in_ready` stays 1 throughout.
- `r_op`=0111, `cres`=0, `stwr`=1 → no strobe, `st` unchanged. Repeat with `cres`=1, {n,z,c,v}=1010 → `st`=0x0000000A the next cycle.
- `r_a1`=0 with `r_op`=0011 and `r_a2`=5 → a single strobe to register 5. Separately, `r_a1`=`r_a2`=7 → strobes r1 then r2, so the file holds r2.
- Dual-write accept, then rst=0 during the first strobe cycle → no second strobe; all outputs reset values next cycle.
